// File: rtl/neuroset_pkg.sv
// Shared types and constants for the neuroset load/compute sequencer.
// Step numbering: 1 = pixel load, even = weight load, odd >= 3 = compute.
package neuroset_pkg;

    localparam int STEP_W = 5;

    localparam logic [STEP_W-1:0] STEP_PIXEL = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_REQ  = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_CALC_REQ  = 3'd3,
        S_CALC_WAIT = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    function automatic logic [STEP_W-1:0] last_step(
        input int unsigned n
    );
        return STEP_W'(2 * n + 1);
    endfunction

endpackage

// File: rtl/load_step_scheduler_if.sv
// Handshake bundle between the step scheduler and its GO source,
// loader and engine.
interface load_step_scheduler_if #(
    parameter int CNT_W = 16
);
    import neuroset_pkg::*;

    logic              go;
    logic              abort;
    logic              load_done;
    logic              calc_done;
    logic              load_start;
    logic              calc_start;
    logic [STEP_W-1:0] step_out;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  busy_cycles;

    modport master (
        input  go,
        input  abort,
        input  load_done,
        input  calc_done,
        output load_start,
        output calc_start,
        output step_out,
        output busy,
        output done,
        output error,
        output busy_cycles
    );

    modport slave (
        output go,
        output abort,
        output load_done,
        output calc_done,
        input  load_start,
        input  calc_start,
        input  step_out,
        input  busy,
        input  done,
        input  error,
        input  busy_cycles
    );

endinterface

// File: rtl/step_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and
// flags expiry on the cycle whose edge completes TIMEOUT waiting cycles.
module step_watchdog #(
    parameter int TIMEOUT = 16383
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && cnt_q != LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIM);

endmodule

// File: rtl/load_step_scheduler.sv
// Sequencer for the pixel load then per-layer weight-load/compute
// pairs, with start pulses, done handshakes and a wait watchdog.
module load_step_scheduler
    import neuroset_pkg::*;
#(
    parameter int NUM_LAYERS = 7,
    parameter int TIMEOUT    = 16383,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_step_scheduler_if.master bus
);

    localparam logic [STEP_W-1:0] LAST = last_step(NUM_LAYERS);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ls_q, ls_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;

    logic in_wait;
    logic expired;

    assign in_wait = (state_q == S_LOAD_WAIT) ||
                     (state_q == S_CALC_WAIT);

    step_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        done_d  = 1'b0;
        bcnt_d  = bcnt_q;
        if (busy_q && bcnt_q != CNT_MAX) begin
            bcnt_d = bcnt_q + 1'b1;
        end

        // abort outranks go, done pulses and the watchdog alike
        if (bus.abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            bcnt_d  = bcnt_q;
        end else begin
            unique case (state_q)
                S_IDLE, S_ERROR: begin
                    if (bus.go) begin
                        state_d = S_LOAD_REQ;
                        step_d  = STEP_PIXEL;
                        err_d   = 1'b0;
                        bcnt_d  = '0;
                    end
                end
                S_LOAD_REQ: begin
                    state_d = S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    if (bus.load_done) begin
                        step_d  = step_q + 1'b1;
                        state_d = (step_q == STEP_PIXEL) ?
                                  S_LOAD_REQ : S_CALC_REQ;
                    end else if (expired) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
                S_CALC_REQ: begin
                    state_d = S_CALC_WAIT;
                end
                S_CALC_WAIT: begin
                    if (bus.calc_done) begin
                        if (step_q == LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            step_d  = step_q + 1'b1;
                            state_d = S_LOAD_REQ;
                        end
                    end else if (expired) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        ls_d   = (state_d == S_LOAD_REQ);
        cs_d   = (state_d == S_CALC_REQ);
        busy_d = (state_d != S_IDLE) && (state_d != S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            ls_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ls_q    <= ls_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign bus.load_start  = ls_q;
    assign bus.calc_start  = cs_q;
    assign bus.step_out    = step_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.busy_cycles = bcnt_q;

endmodule

// File: tb/tb_load_step_scheduler.sv
// Directed bench for load_step_scheduler: vector table plus
// multi-cycle sequences for flow, watchdog, reset and saturation.
module tb_load_step_scheduler;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    load_step_scheduler_if #(.CNT_W(16)) aif ();
    load_step_scheduler_if #(.CNT_W(4))  bif ();

    load_step_scheduler #(
        .NUM_LAYERS (2),
        .TIMEOUT    (8),
        .CNT_W      (16)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (aif)
    );

    load_step_scheduler #(
        .NUM_LAYERS (1),
        .TIMEOUT    (40),
        .CNT_W      (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       go;
        logic       abort;
        logic       ld;
        logic       cd;
        logic [4:0] step;
        logic       ls;
        logic       cs;
        logic       busy;
        logic       done;
        logic       err;
        int         bc;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] a_outs();
        return {aif.load_start, aif.calc_start, aif.step_out,
                aif.busy, aif.done, aif.error, aif.busy_cycles};
    endfunction

    function automatic logic [63:0] b_outs();
        return {bif.load_start, bif.calc_start, bif.step_out,
                bif.busy, bif.done, bif.error, bif.busy_cycles};
    endfunction

    task automatic a_clear();
        aif.go        = 1'b0;
        aif.abort     = 1'b0;
        aif.load_done = 1'b0;
        aif.calc_done = 1'b0;
    endtask

    task automatic run_flow();
        int   lcnt  = 0;
        int   ccnt  = 0;
        int   nev   = 0;
        int   nbusy = 0;
        int   ndone = 0;
        bit   fin   = 0;
        byte  kind[8];
        int   stp[8];
        string order = "LLCLC";
        @(negedge clk);
        aif.go = 1'b1;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            a_clear();
            if (aif.busy) nbusy++;
            if (aif.done) begin
                ndone++;
                fin = 1;
            end
            if (aif.load_start && nev < 8) begin
                kind[nev] = "L";
                stp[nev]  = int'(aif.step_out);
                nev++;
                lcnt = 4;
            end
            if (aif.calc_start && nev < 8) begin
                kind[nev] = "C";
                stp[nev]  = int'(aif.step_out);
                nev++;
                ccnt = 4;
            end
            if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) aif.load_done = 1'b1;
            end
            if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) aif.calc_done = 1'b1;
            end
        end
        chk("flow.finished", 64'(fin), 64'd1);
        chk("flow.starts", 64'(nev), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("flow.step%0d", i),
                64'(stp[i]), 64'(i + 1));
            chk($sformatf("flow.kind%0d", i),
                64'(kind[i]), 64'(order[i]));
        end
        chk("flow.busy_cycles", 64'(aif.busy_cycles), 64'(nbusy));
        chk("flow.busy_cycles_20", 64'(aif.busy_cycles), 64'd20);
        chk("flow.final_step", 64'(aif.step_out), 64'd5);
        chk("flow.busy_after", 64'(aif.busy), 64'd0);
        repeat (5) begin
            @(negedge clk);
            if (aif.done) ndone++;
        end
        chk("flow.done_count", 64'(ndone), 64'd1);
    endtask

    initial begin
        // go, abort, ld, cd, step, ls, cs, busy, done, err, bc
        v[0]  = '{0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0};
        v[1]  = '{1, 0, 0, 0, 5'd1, 1, 0, 1, 0, 0, 0};
        v[2]  = '{1, 0, 0, 0, 5'd1, 0, 0, 1, 0, 0, 1};
        v[3]  = '{0, 0, 0, 1, 5'd1, 0, 0, 1, 0, 0, 2};
        v[4]  = '{0, 0, 1, 0, 5'd2, 1, 0, 1, 0, 0, 3};
        v[5]  = '{0, 0, 1, 0, 5'd2, 0, 0, 1, 0, 0, 4};
        v[6]  = '{0, 0, 1, 0, 5'd3, 0, 1, 1, 0, 0, 5};
        v[7]  = '{0, 0, 1, 0, 5'd3, 0, 0, 1, 0, 0, 6};
        v[8]  = '{0, 0, 1, 0, 5'd3, 0, 0, 1, 0, 0, 7};
        v[9]  = '{0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0, 7};
        v[10] = '{0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 7};
        v[11] = '{1, 0, 0, 0, 5'd1, 1, 0, 1, 0, 0, 0};
        v[12] = '{0, 1, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0};
        v[13] = '{0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0, 0};

        a_clear();
        bif.go        = 1'b0;
        bif.abort     = 1'b0;
        bif.load_done = 1'b0;
        bif.calc_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.a", a_outs(), 64'd0);
        chk("reset.b", b_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            aif.go        = v[i].go;
            aif.abort     = v[i].abort;
            aif.load_done = v[i].ld;
            aif.calc_done = v[i].cd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.step", i),
                64'(aif.step_out), 64'(v[i].step));
            chk($sformatf("vec%0d.ctl", i),
                64'({aif.load_start, aif.calc_start, aif.busy,
                     aif.done, aif.error}),
                64'({v[i].ls, v[i].cs, v[i].busy,
                     v[i].done, v[i].err}));
            chk($sformatf("vec%0d.bc", i),
                64'(aif.busy_cycles), 64'(v[i].bc));
        end
        @(negedge clk);
        a_clear();

        run_flow();

        // watchdog: answer the pixel load, never the step-2 load
        begin
            int first = 0;
            @(negedge clk) aif.go = 1'b1;
            @(negedge clk) aif.go = 1'b0;
            @(negedge clk) aif.load_done = 1'b1;
            @(negedge clk) aif.load_done = 1'b0;
            chk("wd.req2", 64'({aif.load_start, aif.step_out}),
                64'({1'b1, 5'd2}));
            @(posedge clk);
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (aif.error) begin
                    first = k;
                    break;
                end
            end
            chk("wd.latency", 64'(first), 64'd8);
            chk("wd.step", 64'(aif.step_out), 64'd2);
            chk("wd.busy", 64'(aif.busy), 64'd0);
            repeat (3) @(negedge clk);
            chk("wd.quiet", 64'({aif.load_start, aif.calc_start,
                aif.error}), 64'({1'b0, 1'b0, 1'b1}));
            @(negedge clk) aif.go = 1'b1;
            @(posedge clk);
            #1;
            chk("wd.restart", 64'({aif.step_out, aif.error,
                aif.load_start, aif.busy}),
                64'({5'd1, 1'b0, 1'b1, 1'b1}));
            chk("wd.restart_bc", 64'(aif.busy_cycles), 64'd0);
            @(negedge clk);
            aif.go    = 1'b0;
            aif.abort = 1'b1;
            @(negedge clk) aif.abort = 1'b0;
        end

        // asynchronous reset while waiting on a compute
        @(negedge clk) aif.go = 1'b1;
        @(negedge clk) aif.go = 1'b0;
        @(negedge clk) aif.load_done = 1'b1;
        @(negedge clk) aif.load_done = 1'b0;
        @(negedge clk) aif.load_done = 1'b1;
        @(negedge clk) aif.load_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.pre", 64'({aif.step_out, aif.busy, aif.calc_start}),
            64'({5'd3, 1'b1, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async", a_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst.idle%0d", i), a_outs(), 64'd0);
        end

        // busy_cycles saturation on the 4-bit counter
        begin
            bit got = 0;
            @(negedge clk) bif.go = 1'b1;
            @(negedge clk) bif.go = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("sat.mid", 64'(bif.busy_cycles), 64'd10);
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bif.error) begin
                    got = 1;
                    break;
                end
            end
            chk("sat.error", 64'(got), 64'd1);
            chk("sat.value", 64'(bif.busy_cycles), 64'd15);
            repeat (3) @(negedge clk);
            chk("sat.hold", 64'(bif.busy_cycles), 64'd15);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
